// File: rtl/cm0_pkg.sv
// Shared encodings for the Cortex-M0 execute-stage data-processing units.
package cm0_pkg;

    // Logic operation select
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_ORR = 2'b01,
        OP_EOR = 2'b10,
        OP_BIC = 2'b11
    } op_e;

    // Barrel shifter type select; ROR with a zero amount means RRX
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

endpackage

// File: rtl/barrel_shift.sv
// Combinational barrel shifter for the register operand.
// Produces the shifted operand and the shifter carry-out.
module barrel_shift
    import cm0_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic [W-1:0]   rm,
    input  logic [SHW-1:0] shamt,
    input  logic [1:0]     stype,
    input  logic           carry_in,
    output logic [W-1:0]   op2,
    output logic           sc
);

    // W - n wraps naturally in SHW bits; only used when n != 0
    logic [SHW-1:0] shamt_neg;
    logic [SHW-1:0] shamt_m1;
    logic           shamt_zero;

    assign shamt_neg  = SHW'(0) - shamt;
    assign shamt_m1   = shamt - SHW'(1);
    assign shamt_zero = (shamt == '0);

    // Select the shift result and the last bit shifted out
    always_comb begin
        op2 = rm;
        sc  = carry_in;
        case (shift_e'(stype))
            SH_LSL: begin
                if (!shamt_zero) begin
                    op2 = rm << shamt;
                    sc  = rm[shamt_neg];
                end
            end
            SH_LSR: begin
                if (!shamt_zero) begin
                    op2 = rm >> shamt;
                    sc  = rm[shamt_m1];
                end
            end
            SH_ASR: begin
                if (!shamt_zero) begin
                    op2 = $signed(rm) >>> shamt;
                    sc  = rm[shamt_m1];
                end
            end
            SH_ROR: begin
                if (shamt_zero) begin
                    // RRX: rotate through the incoming carry by one
                    op2 = {carry_in, rm[W-1:1]};
                    sc  = rm[0];
                end else begin
                    op2 = (rm >> shamt) | (rm << shamt_neg);
                    sc  = rm[shamt_m1];
                end
            end
            default: begin
                op2 = rm;
                sc  = carry_in;
            end
        endcase
    end

endmodule

// File: rtl/op_logic.sv
// Two-stage pipelined AND/ORR/EOR/BIC unit with shifted-register or
// immediate second operand and conditional N/Z/C flag update.
// Stage 1 registers the shifter output; stage 2 registers the result.
module op_logic
    import cm0_pkg::*;
#(
    parameter int W    = 32,
    parameter int SHW  = $clog2(W),
    parameter int IMMW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            imm_sel,
    input  logic            set_flags,
    input  logic [W-1:0]    rn,
    input  logic [W-1:0]    rm,
    input  logic [IMMW-1:0] imm,
    input  logic [SHW-1:0]  shamt,
    input  logic [1:0]      stype,
    input  logic            carry_in,
    input  logic            zero_in,
    input  logic            neg_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    rd,
    output logic            carry_out,
    output logic            zero_out,
    output logic            neg_out,
    output logic            flags_wr
);

    // Handshake
    logic s1_v_q;
    logic s2_v_q;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !s2_v_q || out_ready;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1 datapath
    logic [W-1:0] sh_op2;
    logic         sh_sc;
    logic [W-1:0] op2_d;
    logic         sc_d;

    barrel_shift #(
        .W   (W),
        .SHW (SHW)
    ) u_shift (
        .rm       (rm),
        .shamt    (shamt),
        .stype    (stype),
        .carry_in (carry_in),
        .op2      (sh_op2),
        .sc       (sh_sc)
    );

    // Immediate bypasses the shifter and keeps the incoming carry
    always_comb begin
        op2_d = sh_op2;
        sc_d  = sh_sc;
        if (imm_sel) begin
            op2_d = {{(W-IMMW){1'b0}}, imm};
            sc_d  = carry_in;
        end
    end

    logic [W-1:0] s1_rn_q;
    logic [W-1:0] s1_op2_q;
    op_e          s1_op_q;
    logic         s1_sc_q;
    logic         s1_s_q;
    logic         s1_c_q;
    logic         s1_z_q;
    logic         s1_n_q;

    // Stage 1 register: load on advance, hold while blocked
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_rn_q  <= '0;
            s1_op2_q <= '0;
            s1_op_q  <= OP_AND;
            s1_sc_q  <= 1'b0;
            s1_s_q   <= 1'b0;
            s1_c_q   <= 1'b0;
            s1_z_q   <= 1'b0;
            s1_n_q   <= 1'b0;
        end else if (s1_adv) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_rn_q  <= rn;
                s1_op2_q <= op2_d;
                s1_op_q  <= op_e'(op);
                s1_sc_q  <= sc_d;
                s1_s_q   <= set_flags;
                s1_c_q   <= carry_in;
                s1_z_q   <= zero_in;
                s1_n_q   <= neg_in;
            end
        end
    end

    // Stage 2 datapath
    logic [W-1:0] rd_d;
    logic         c_d;
    logic         z_d;
    logic         n_d;

    // Logic operation and flag selection
    always_comb begin
        rd_d = '0;
        case (s1_op_q)
            OP_AND:  rd_d = s1_rn_q &  s1_op2_q;
            OP_ORR:  rd_d = s1_rn_q |  s1_op2_q;
            OP_EOR:  rd_d = s1_rn_q ^  s1_op2_q;
            OP_BIC:  rd_d = s1_rn_q & ~s1_op2_q;
            default: rd_d = '0;
        endcase
        c_d = s1_c_q;
        z_d = s1_z_q;
        n_d = s1_n_q;
        if (s1_s_q) begin
            c_d = s1_sc_q;
            z_d = (rd_d == '0);
            n_d = rd_d[W-1];
        end
    end

    logic [W-1:0] rd_q;
    logic         c_q;
    logic         z_q;
    logic         n_q;
    logic         fw_q;

    // Stage 2 register: outputs stay frozen while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_q <= 1'b0;
            rd_q   <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            fw_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                rd_q <= rd_d;
                c_q  <= c_d;
                z_q  <= z_d;
                n_q  <= n_d;
                fw_q <= s1_s_q;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign rd        = rd_q;
    assign carry_out = c_q;
    assign zero_out  = z_q;
    assign neg_out   = n_q;
    assign flags_wr  = fw_q;

endmodule

// File: tb/tb_op_logic.sv
// Self-checking bench for op_logic: directed cases, back-pressure,
// mid-stream reset and randomized traffic against a behavioural model.
module tb_op_logic;

    localparam int W    = 32;
    localparam int SHW  = 5;
    localparam int IMMW = 12;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic            imm_sel;
    logic            set_flags;
    logic [W-1:0]    rn;
    logic [W-1:0]    rm;
    logic [IMMW-1:0] imm;
    logic [SHW-1:0]  shamt;
    logic [1:0]      stype;
    logic            carry_in;
    logic            zero_in;
    logic            neg_in;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    rd;
    logic            carry_out;
    logic            zero_out;
    logic            neg_out;
    logic            flags_wr;

    op_logic #(
        .W    (W),
        .SHW  (SHW),
        .IMMW (IMMW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .imm_sel   (imm_sel),
        .set_flags (set_flags),
        .rn        (rn),
        .rm        (rm),
        .imm       (imm),
        .shamt     (shamt),
        .stype     (stype),
        .carry_in  (carry_in),
        .zero_in   (zero_in),
        .neg_in    (neg_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .neg_out   (neg_out),
        .flags_wr  (flags_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected result; f = {N, Z, C, flags_wr}
    typedef struct {
        logic [31:0] rd;
        logic [3:0]  f;
        int          acc;
        bit          lat;
        bit          fix;
        logic [31:0] fix_rd;
        logic [3:0]  fix_f;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    bit          lat_flag = 0;
    bit          fix_flag = 0;
    logic [31:0] fix_rd   = '0;
    logic [3:0]  fix_f    = '0;

    always @(posedge clk) cyc++;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, expv);
        end
    endtask

    // Reference model: shift by plain wide arithmetic / bit-by-bit rotation
    function automatic exp_t model(logic [1:0] o, logic isel, logic s,
                                   logic [31:0] a, logic [31:0] b,
                                   logic [11:0] im, logic [4:0] sh,
                                   logic [1:0] st, logic ci, logic zi, logic ni);
        exp_t               e;
        logic [31:0]        op2;
        logic               sc;
        logic [63:0]        w;
        logic signed [63:0] ws;
        logic [31:0]        x;
        logic [31:0]        r;
        int                 n;
        n   = int'(sh);
        op2 = b;
        sc  = ci;
        if (isel) begin
            op2 = {20'b0, im};
            sc  = ci;
        end else if (st == 2'd0) begin
            if (n != 0) begin
                w   = {32'b0, b} << n;
                op2 = w[31:0];
                sc  = w[32];
            end
        end else if (st == 2'd1) begin
            if (n != 0) begin
                w   = {b, 32'b0} >> n;
                op2 = w[63:32];
                sc  = w[31];
            end
        end else if (st == 2'd2) begin
            if (n != 0) begin
                ws  = $signed({b, 32'b0});
                ws  = ws >>> n;
                op2 = ws[63:32];
                sc  = ws[31];
            end
        end else begin
            if (n == 0) begin
                op2 = {ci, b[31:1]};
                sc  = b[0];
            end else begin
                x = b;
                for (int i = 0; i < n; i++) begin
                    sc = x[0];
                    x  = {x[0], x[31:1]};
                end
                op2 = x;
            end
        end
        case (o)
            2'd0:    r = a & op2;
            2'd1:    r = a | op2;
            2'd2:    r = a ^ op2;
            default: r = a & ~op2;
        endcase
        e.rd     = r;
        e.f      = s ? {r[31], (r == 32'd0), sc, 1'b1} : {ni, zi, ci, 1'b0};
        e.acc    = 0;
        e.lat    = 0;
        e.fix    = 0;
        e.fix_rd = '0;
        e.fix_f  = '0;
        return e;
    endfunction

    // Monitor: retire outputs against the queue, then record new accepts
    exp_t        e_mon;
    logic [35:0] hold;
    bit          hold_v = 0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_v = 0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_rd", rd, hold[35:4]);
                chk("hold_flags", {28'b0, neg_out, zero_out, carry_out, flags_wr},
                    {28'b0, hold[3:0]});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    e_mon = q.pop_front();
                    chk("rd", rd, e_mon.rd);
                    chk("flags_nzcw", {28'b0, neg_out, zero_out, carry_out, flags_wr},
                        {28'b0, e_mon.f});
                    if (e_mon.fix) begin
                        chk("rd_directed", rd, e_mon.fix_rd);
                        chk("flags_directed", {28'b0, neg_out, zero_out, carry_out, flags_wr},
                            {28'b0, e_mon.fix_f});
                    end
                    if (e_mon.lat)
                        chk("latency", 32'(cyc - e_mon.acc), 32'd2);
                end
            end
            hold_v = out_valid && !out_ready;
            hold   = {rd, neg_out, zero_out, carry_out, flags_wr};
            if (in_valid && in_ready) begin
                e_mon = model(op, imm_sel, set_flags, rn, rm, imm, shamt, stype,
                              carry_in, zero_in, neg_in);
                e_mon.acc    = cyc;
                e_mon.lat    = lat_flag;
                e_mon.fix    = fix_flag;
                e_mon.fix_rd = fix_rd;
                e_mon.fix_f  = fix_f;
                q.push_back(e_mon);
            end
        end
    end

    task automatic set_req(logic [1:0] o, logic isel, logic s, logic [31:0] a,
                           logic [31:0] b, logic [11:0] im, logic [4:0] sh,
                           logic [1:0] st, logic c, logic z, logic nn);
        op = o; imm_sel = isel; set_flags = s; rn = a; rm = b; imm = im;
        shamt = sh; stype = st; carry_in = c; zero_in = z; neg_in = nn;
    endtask

    task automatic set_rand_req();
        logic [4:0] sh;
        sh = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 4) == 0) sh = 5'd0;
        set_req(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), $urandom(), $urandom(),
                12'($urandom_range(0, 4095)), sh, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    endtask

    // Present the current request until accepted (bounded)
    task automatic send(bit rnd);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        fix_flag = 0;
        lat_flag = 0;
        chk("accept_within_bound", {31'b0, acc}, 32'd1);
    endtask

    task automatic idle(int n, bit rnd);
        for (int k = 0; k < n; k++) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_req(2'd0, 1'b0, 1'b0, '0, '0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_flags", {28'b0, neg_out, zero_out, carry_out, flags_wr}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // AND, LSL #16, S=1
        set_req(2'd0, 1'b0, 1'b1, 32'hFFFF0000, 32'h00008001, 12'h000, 5'd16, 2'd0,
                1'b1, 1'b0, 1'b0);
        lat_flag = 1; fix_flag = 1; fix_rd = 32'h80010000; fix_f = 4'b1001;
        send(0);
        // EOR, RRX, S=1
        set_req(2'd2, 1'b0, 1'b1, 32'h80000000, 32'h00000001, 12'h000, 5'd0, 2'd3,
                1'b1, 1'b0, 1'b0);
        lat_flag = 1; fix_flag = 1; fix_rd = 32'h00000000; fix_f = 4'b0111;
        send(0);
        // ORR, ASR #4, S=0, flags pass through
        set_req(2'd1, 1'b0, 1'b0, 32'h00000000, 32'h80000008, 12'h000, 5'd4, 2'd2,
                1'b0, 1'b1, 1'b0);
        lat_flag = 1; fix_flag = 1; fix_rd = 32'hF8000000; fix_f = 4'b0100;
        send(0);
        // BIC immediate, S=1
        set_req(2'd3, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678, 12'hFFF, 5'd7, 2'd0,
                1'b1, 1'b0, 1'b0);
        lat_flag = 1; fix_flag = 1; fix_rd = 32'hFFFFF000; fix_f = 4'b1011;
        send(0);
        idle(4, 0);

        // Back-pressure: fill the pipe with the consumer stalled
        out_ready = 1'b0;
        set_rand_req(); send(0);
        set_rand_req(); send(0);
        @(negedge clk);
        chk("in_ready_full", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        set_rand_req();
        in_valid = 1'b1;
        idle(2, 0);
        out_ready = 1'b1;
        send(0);
        set_rand_req(); send(0);
        idle(6, 0);

        // Reset with two results in flight
        set_rand_req(); send(0);
        set_rand_req(); send(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_rd", rd, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        idle(6, 0);

        // Randomized traffic with random consumer stalls
        for (int i = 0; i < 300; i++) begin
            set_rand_req();
            send(1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1);
        end

        // Drain
        out_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        idle(2, 0);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/op_logic.md
# op_logic

Parametrised, pipelined data-processing logic unit for the Cortex-M0 execute stage: AND, ORR, EOR and BIC on a register or zero-extended immediate second operand. The register operand passes through a barrel shifter (LSL/LSR/ASR/ROR/RRX) that produces the shifter carry-out. Transactions flow through a two-stage valid/ready pipeline, and each result carries its conditionally updated N/Z/C flags. It replaces the single-op, edge-triggered AND unit with a clocked, back-pressurable block.

## Interface
Parameters:
- `W`, 32, datapath width; ≥ 8, power of two
- `SHW`, $clog2(W), shift-amount width
- `IMMW`, 12, immediate width; < W

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  block can accept a request
- `op`  in  2  00 AND, 01 ORR, 10 EOR, 11 BIC (Rn & ~op2)
- `imm_sel`  in  1  1 = op2 is the zero-extended `imm`; 0 = op2 is shifted `rm`
- `set_flags`  in  1  S bit
- `rn`, `rm`  in  W  source operands
- `imm`  in  IMMW  immediate operand
- `shamt`  in  SHW  shift amount
- `stype`  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- `carry_in`, `zero_in`, `neg_in`  in  1  current APSR flags
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `rd`  out  W  result
- `carry_out`, `zero_out`, `neg_out`  out  1  next flag values
- `flags_wr`  out  1  high when `set_flags` was set for this result

## Operation
- A request is accepted on a cycle where `in_valid && in_ready`. All inputs, including the flag inputs, are sampled on that edge only.
- **Stage 1 (shift).** Produces `op2` and shifter carry `sc`, and registers them with `rn`, `op`, S and the flags.
  - `imm_sel=1`: `op2 = {0, imm}`, `sc = carry_in`.
  - `shamt=0` with LSL, LSR or ASR: `op2 = rm`, `sc = carry_in`.
  - LSL n: `op2 = rm << n`, `sc = rm[W-n]`.
  - LSR n: `op2 = rm >> n`, `sc = rm[n-1]`.
  - ASR n: arithmetic shift right (sign fill), `sc = rm[n-1]`.
  - ROR n (n ≠ 0): `op2 = rotate right`, `sc = rm[n-1]`.
  - ROR with `shamt=0` is RRX: `op2 = {carry_in, rm[W-1:1]}`, `sc = rm[0]`.
- **Stage 2 (logic).** Registers `rd = rn OP op2`, where OP is AND, OR, XOR, or AND-NOT.
  - If S: `neg_out = rd[W-1]`, `zero_out = (rd == 0)`, `carry_out = sc`.
  - Otherwise the three flag outputs repeat the sampled flag inputs.
  - `flags_wr = S`. The block has no overflow flag.
- All arithmetic is performed at width W. No bit wider than W is kept.

## Timing
- Latency: 2 cycles from acceptance to `out_valid`, given `out_ready` held high. Throughput: 1 per cycle.
- Handshake: `s2_adv = !s2_v || out_ready`, `s1_adv = !s1_v || s2_adv`, `in_ready = s1_adv`.
  - `in_ready` is combinational from `out_ready`. There is no other combinational path from input to output.
- While `out_valid && !out_ready`, `rd` and the flag outputs stay stable. Stage 1 holds its data while it is blocked.
- Simultaneous accept and drain in the same cycle on a full pipe: both happen, with no bubble and no loss.
- Reset values: both valids 0, `rd=0`, all flag outputs 0, `flags_wr=0`.
  - `in_ready` reads 1 from the first cycle after reset.
  - Reset asserted mid-stream drops all in-flight results. No `out_valid` is produced for them.

## Structure
- Shared package `cm0_pkg`: op encodings (`OP_AND/ORR/EOR/BIC`) and shift encodings (`SH_LSL/LSR/ASR/ROR`), reused by the arithmetic unit.
- One sub-module, `barrel_shift` (parameters `W`, `SHW`): purely combinational, outputs `{op2, sc}`.
- `op_logic` owns both pipeline registers and the handshake.

## Test plan
- AND, LSL #16, S=1, `rn=FFFF0000`, `rm=00008001`, `carry_in=1` → `rd=80010000`, N=1, Z=0, C=0, `flags_wr=1`, 2 cycles after accept.
- EOR, RRX (ROR #0), S=1, `rn=80000000`, `rm=00000001`, `carry_in=1` → `op2=80000000`, `rd=0`, Z=1, N=0, C=1.
- ASR #4, ORR, S=0, `rn=0`, `rm=80000008`, flags_in N=0, Z=1, C=0 → `rd=F8000000`, outputs N=0, Z=1, C=0, `flags_wr=0`.
- BIC imm, S=1, `rn=FFFFFFFF`, `imm=FFF`, `carry_in=1` → `rd=FFFFF000`, N=1, Z=0, C=1.
- Back-pressure: 4 back-to-back requests with `out_ready=0` for 5 cycles.
  - `in_ready` falls after the 2nd accept.
  - All 4 results then emerge in order with no loss or duplication.
- Two requests in flight, `rst=1` for 1 cycle → `out_valid=0`, `rd=0`, `in_ready=1` next cycle, no stale result afterwards.
